// File: rtl/sprite_pkg.sv
// Shared sprite-engine types: OAM entry layout, sprite config handed to the manager,
// height encoding and the scanner FSM state type.
package sprite_pkg;

    localparam int SPR_NUM_SPRITES = 64;
    localparam int SPR_IDX_W       = $clog2(SPR_NUM_SPRITES);

    // Height code h selects (h+1)*8 rows
    localparam logic [1:0] SPR_H_8    = 2'd0;
    localparam logic [1:0] SPR_H_16   = 2'd1;
    localparam logic [1:0] SPR_H_24   = 2'd2;
    localparam logic [1:0] SPR_H_32   = 2'd3;
    localparam logic [5:0] SPR_H_UNIT = 6'd8;

    typedef struct packed {
        logic [9:0] tile;
        logic [3:0] palette;
        logic [8:0] x;
        logic [7:0] y;
        logic [1:0] w;
        logic [1:0] h;
        logic       x_mirror;
        logic       y_mirror;
        logic       fg_prio;
        logic       bg_prio;
    } oam_entry_t;

    typedef struct packed {
        logic [9:0] tile;
        logic [3:0] palette;
        logic [8:0] x;
        logic [7:0] y;
        logic [1:0] w;
        logic [1:0] h;
        logic       x_mirror;
        logic       y_mirror;
        logic       fg_prio;
        logic       bg_prio;
    } sprite_conf_t;

    typedef enum logic [1:0] {
        ST_READ = 2'd0,
        ST_EVAL = 2'd1,
        ST_HOLD = 2'd2,
        ST_DONE = 2'd3
    } scan_state_t;

    function automatic logic [5:0] sprite_height(input logic [1:0] h);
        return {1'b0, h, 3'b000} + SPR_H_UNIT;
    endfunction

    function automatic sprite_conf_t entry_to_conf(input oam_entry_t e);
        sprite_conf_t c;
        c.tile     = e.tile;
        c.palette  = e.palette;
        c.x        = e.x;
        c.y        = e.y;
        c.w        = e.w;
        c.h        = e.h;
        c.x_mirror = e.x_mirror;
        c.y_mirror = e.y_mirror;
        c.fg_prio  = e.fg_prio;
        c.bg_prio  = e.bg_prio;
        return c;
    endfunction

endpackage

// File: rtl/sprite_oam_scanner_if.sv
// OAM read port plus the conf_req/conf_ack/conf_exists handshake toward the sprite manager.
// master = scanner side, slave = OAM RAM / manager side.
interface sprite_oam_scanner_if
    import sprite_pkg::*;
#(
    parameter int IDX_W = SPR_IDX_W
);
    logic [IDX_W-1:0] oam_addr;
    logic             oam_read;
    oam_entry_t       oam_data;
    logic             conf_req;
    sprite_conf_t     conf;
    logic             conf_ack;
    logic             conf_exists;

    modport master (
        output oam_addr, oam_read, conf, conf_ack, conf_exists,
        input  oam_data, conf_req
    );

    modport slave (
        input  oam_addr, oam_read, conf, conf_ack, conf_exists,
        output oam_data, conf_req
    );
endinterface

// File: rtl/sprite_y_hit.sv
// Combinational vertical-extent test of one OAM entry against the render row.
// SPRITE_Y_WRAP_EN selects mod-256 wrap of the row distance; default build does not wrap.
module sprite_y_hit
    import sprite_pkg::*;
(
    input  logic [7:0] row,
    input  logic [7:0] y,
    input  logic [1:0] h,
    output logic       hit
);
    logic [5:0] height_s;

    assign height_s = sprite_height(h);

`ifdef SPRITE_Y_WRAP_EN
    logic [7:0] dy_s;

    assign dy_s = row - y;
    assign hit  = ({2'b00, dy_s} < {4'b0000, height_s});
`else
    logic [8:0] dy_s;

    // Bit 8 set means row is above the sprite top
    assign dy_s = {1'b0, row} - {1'b0, y};
    assign hit  = ~dy_s[8] & (dy_s < {3'b000, height_s});
`endif

endmodule

// File: rtl/sprite_oam_scanner.sv
// Per-line OAM walker: reads entries in index order, buffers each row hit and hands it
// to the sprite manager one at a time. Row-wrap behaviour follows SPRITE_Y_WRAP_EN.
module sprite_oam_scanner
    import sprite_pkg::*;
#(
    parameter int NUM_SPRITES = SPR_NUM_SPRITES,
    parameter int IDX_W       = $clog2(NUM_SPRITES)
)(
    input  logic                clock,
    input  logic                reset,
    input  logic                clear,
    input  logic [7:0]          row,
    sprite_oam_scanner_if.master bus
);
    scan_state_t      state_r;
    scan_state_t      state_next_s;
    logic [IDX_W-1:0] idx_r;
    logic [IDX_W-1:0] idx_next_s;
    logic             buf_valid_r;
    sprite_conf_t     conf_r;
    logic             oam_read_r;
    logic [IDX_W-1:0] oam_addr_r;
    logic             conf_exists_r;
    logic             hit_s;
    logic             last_s;
    logic             buf_load_s;
    logic             buf_clr_s;
    logic             conf_ack_s;

    sprite_y_hit u_y_hit (
        .row (row),
        .y   (bus.oam_data.y),
        .h   (bus.oam_data.h),
        .hit (hit_s)
    );

    assign last_s = (idx_r == IDX_W'(NUM_SPRITES - 1));

    // FSM state register
    always_ff @(posedge clock) begin
        if (reset) begin
            state_r <= ST_DONE;
        end else begin
            state_r <= state_next_s;
        end
    end

    // Next-state, index advance, buffer control and the combinational ack
    always_comb begin
        state_next_s = state_r;
        idx_next_s   = idx_r;
        buf_load_s   = 1'b0;
        buf_clr_s    = 1'b0;
        conf_ack_s   = 1'b0;
        if (clear) begin
            state_next_s = ST_READ;
            idx_next_s   = {IDX_W{1'b0}};
            buf_clr_s    = 1'b1;
        end else begin
            case (state_r)
                ST_READ: begin
                    state_next_s = ST_EVAL;
                end
                ST_EVAL: begin
                    if (hit_s) begin
                        buf_load_s   = 1'b1;
                        state_next_s = ST_HOLD;
                    end else if (last_s) begin
                        state_next_s = ST_DONE;
                    end else begin
                        idx_next_s   = idx_r + IDX_W'(1);
                        state_next_s = ST_READ;
                    end
                end
                ST_HOLD: begin
                    if (bus.conf_req && buf_valid_r) begin
                        conf_ack_s = 1'b1;
                        buf_clr_s  = 1'b1;
                        if (last_s) begin
                            state_next_s = ST_DONE;
                        end else begin
                            idx_next_s   = idx_r + IDX_W'(1);
                            state_next_s = ST_READ;
                        end
                    end else begin
                        state_next_s = ST_HOLD;
                    end
                end
                ST_DONE: begin
                    state_next_s = ST_DONE;
                end
                default: begin
                    state_next_s = ST_DONE;
                end
            endcase
        end
    end

    // Index, hit buffer and registered OAM/exists outputs
    always_ff @(posedge clock) begin
        if (reset) begin
            idx_r         <= {IDX_W{1'b0}};
            buf_valid_r   <= 1'b0;
            conf_r        <= '0;
            oam_read_r    <= 1'b0;
            oam_addr_r    <= {IDX_W{1'b0}};
            conf_exists_r <= 1'b0;
        end else begin
            idx_r      <= idx_next_s;
            oam_read_r <= (state_next_s == ST_READ);
            oam_addr_r <= idx_next_s;
            // Held through the cycle DONE is entered so the manager sees every late hit
            conf_exists_r <= clear | (state_r != ST_DONE);
            if (buf_load_s) begin
                buf_valid_r <= 1'b1;
                conf_r      <= entry_to_conf(bus.oam_data);
            end else if (buf_clr_s) begin
                buf_valid_r <= 1'b0;
            end else begin
                buf_valid_r <= buf_valid_r;
            end
        end
    end

    assign bus.oam_read    = oam_read_r;
    assign bus.oam_addr    = oam_addr_r;
    assign bus.conf        = conf_r;
    assign bus.conf_ack    = conf_ack_s;
    assign bus.conf_exists = conf_exists_r;

endmodule
